// File: rtl/dish_ctrl_pkg.sv
// dish_load_ctrl shared types.
// State encoding, fault codes and counter width.
package dish_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOCK   = 3'd1,
    ST_RUN    = 3'd2,
    ST_UNLOCK = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_NO_WATER = 2'b01;
  localparam logic [1:0] FC_DOOR     = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  localparam int CC_W = 8;
  localparam logic [CC_W-1:0] CC_MAX = '1;

endpackage

// File: rtl/dish_load_ctrl_btn_debounce.sv
// Start-button debouncer on an already-synced level.
// Level flips after DEBOUNCE_CYCLES mismatching samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in_s,
  output logic level,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  // count mismatches; flip level and emit rising pulse on the last one
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (in_s != level_q) begin
      if (cnt_q == LAST) begin
        level_d = in_s;
        pulse_d = in_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // debouncer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/dish_load_ctrl.sv
// Dishwasher front-end cycle controller.
// Start/door conditioning, door lock, run watchdog, fault latch.
module dish_load_ctrl
  import dish_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCK_SETTLE     = 4,
  parameter int WASH_TIMEOUT    = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_btn,
  input  logic            door_closed,
  input  logic            water_ok,
  input  logic            done,
  output logic            ready,
  output logic            door_lock,
  output logic            busy,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [CC_W-1:0] cycle_count
);

  localparam int SW = $clog2(LOCK_SETTLE + 1);
  localparam int WW = (WASH_TIMEOUT > 1) ? $clog2(WASH_TIMEOUT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);
  localparam logic [WW-1:0] WD_LAST     = WW'(WASH_TIMEOUT - 1);

  logic start_m_q, start_m_d, start_s_q, start_s_d;
  logic door_m_q, door_m_d, door_s_q, door_s_d;
  logic done_q, done_d;
  logic start_lvl, start_pls, start_pulse, done_rise;

  state_e          state_q, state_d;
  logic [1:0]      fault_code_q, fault_code_d;
  logic [CC_W-1:0] cycle_count_q, cycle_count_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [WW-1:0]   wd_q, wd_d;

  // two-flop synchronisers and done edge history
  always_comb begin
    start_m_d = start_btn;
    start_s_d = start_m_q;
    door_m_d  = door_closed;
    door_s_d  = door_m_q;
    done_d    = done;
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .rst  (rst),
    .in_s (start_s_q),
    .level(start_lvl),
    .pulse(start_pls)
  );

  assign start_pulse = start_pls & start_lvl;
  assign done_rise   = done & ~done_q;

  // next-state, fault latch, settle/watchdog counters, cycle counter
  always_comb begin
    state_d       = state_q;
    fault_code_d  = fault_code_q;
    cycle_count_d = cycle_count_q;
    settle_d      = '0;
    wd_d          = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_pulse && door_s_q) begin
          if (water_ok) begin
            state_d = ST_LOCK;
          end else begin
            state_d      = ST_FAULT;
            fault_code_d = FC_NO_WATER;
          end
        end
      end
      ST_LOCK: begin
        settle_d = settle_q + 1'b1;
        if (!door_s_q) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_DOOR;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        wd_d = wd_q + 1'b1;
        if (done_rise) begin
          state_d = ST_UNLOCK;
        end else if (!door_s_q) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_DOOR;
        end else if (!water_ok) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_NO_WATER;
        end else if (wd_q == WD_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      ST_UNLOCK: begin
        state_d = ST_IDLE;
        if (cycle_count_q != CC_MAX) begin
          cycle_count_d = cycle_count_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (start_pulse && door_s_q && water_ok) begin
          state_d      = ST_IDLE;
          fault_code_d = FC_NONE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        fault_code_d = FC_NONE;
      end
    endcase
  end

  // all controller registers
  always_ff @(posedge clk) begin
    if (rst) begin
      start_m_q     <= 1'b0;
      start_s_q     <= 1'b0;
      door_m_q      <= 1'b0;
      door_s_q      <= 1'b0;
      done_q        <= 1'b0;
      state_q       <= ST_IDLE;
      fault_code_q  <= FC_NONE;
      cycle_count_q <= '0;
      settle_q      <= '0;
      wd_q          <= '0;
    end else begin
      start_m_q     <= start_m_d;
      start_s_q     <= start_s_d;
      door_m_q      <= door_m_d;
      door_s_q      <= door_s_d;
      done_q        <= done_d;
      state_q       <= state_d;
      fault_code_q  <= fault_code_d;
      cycle_count_q <= cycle_count_d;
      settle_q      <= settle_d;
      wd_q          <= wd_d;
    end
  end

  // Moore outputs from the registered state
  always_comb begin
    ready     = (state_q == ST_RUN);
    door_lock = (state_q == ST_LOCK) || (state_q == ST_RUN);
    busy      = (state_q == ST_LOCK) || (state_q == ST_RUN);
    fault     = (state_q == ST_FAULT);
  end

  assign fault_code  = fault_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_dish_load_ctrl.sv
// Directed bench for dish_load_ctrl.
// Expectations are queued per cycle and checked as cycles elapse.
module tb_dish_load_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn, door_closed, water_ok, done;
  logic       ready, door_lock, busy, fault;
  logic [1:0] fault_code;
  logic [7:0] cycle_count;

  dish_load_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LOCK_SETTLE    (4),
    .WASH_TIMEOUT   (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .door_closed(door_closed),
    .water_ok   (water_ok),
    .done       (done),
    .ready      (ready),
    .door_lock  (door_lock),
    .busy       (busy),
    .fault      (fault),
    .fault_code (fault_code),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   cc      = 0;

  function automatic logic [13:0] obs();
    return {ready, door_lock, busy, fault, fault_code, cycle_count};
  endfunction

  function automatic logic [13:0] v_idle(int c);
    return {4'b0000, 2'b00, 8'(c)};
  endfunction

  function automatic logic [13:0] v_lock(int c);
    return {4'b0110, 2'b00, 8'(c)};
  endfunction

  function automatic logic [13:0] v_run(int c);
    return {4'b1110, 2'b00, 8'(c)};
  endfunction

  function automatic logic [13:0] v_flt(logic [1:0] fc, int c);
    return {4'b0001, fc, 8'(c)};
  endfunction

  task automatic expect_at(input int c, input string tag,
                           input logic [13:0] v);
    sb.push_back('{c, tag, v});
  endtask

  task automatic step(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].c <= cyc) begin
        e = sb.pop_front();
        n_tests++;
        if (e.c < cyc) begin
          n_fail++;
          $error("FAIL %s: check for cycle %0d missed at %0d",
                 e.tag, e.c, cyc);
        end else begin
          assert (obs() === e.v) else begin
            n_fail++;
            $error("FAIL %s @%0d: observed %h expected %h",
                   e.tag, cyc, obs(), e.v);
          end
        end
      end
    end
  endtask

  task automatic press_to_run(output int r);
    int p;
    p = cyc;
    start_btn = 1'b1;
    expect_at(p + 6, "pre_lock", v_idle(cc));
    expect_at(p + 7, "lock", v_lock(cc));
    expect_at(p + 10, "settle", v_lock(cc));
    expect_at(p + 11, "run", v_run(cc));
    step(11);
    start_btn = 1'b0;
    r = cyc;
  endtask

  task automatic press_expect(input string tag, input logic [13:0] v);
    int p;
    p = cyc;
    start_btn = 1'b1;
    expect_at(p + 7, tag, v);
    step(7);
    start_btn = 1'b0;
    step(8);
  endtask

  initial begin
    int r;
    int p;

    rst         = 1'b1;
    start_btn   = 1'($urandom);
    door_closed = 1'($urandom);
    water_ok    = 1'($urandom);
    done        = 1'($urandom);
    expect_at(1, "rst1", v_idle(0));
    expect_at(2, "rst2", v_idle(0));
    step(2);

    rst         = 1'b0;
    start_btn   = 1'b0;
    door_closed = 1'b1;
    water_ok    = 1'b1;
    done        = 1'b0;
    step(8);

    // normal cycle, press in cycle 10
    start_btn = 1'b1;
    expect_at(16, "pulse_idle", v_idle(0));
    expect_at(17, "lock17", v_lock(0));
    expect_at(20, "lock20", v_lock(0));
    expect_at(21, "ready21", v_run(0));
    expect_at(30, "run30", v_run(0));
    step(20);
    done      = 1'b1;
    start_btn = 1'b0;
    expect_at(31, "unlock31", v_idle(0));
    expect_at(32, "idle32", v_idle(1));
    cc = 1;
    expect_at(36, "done_level", v_idle(1));
    step(8);
    done = 1'b0;

    // bounce: 2-cycle pulses never reach the debounce threshold
    for (int c = 41; c <= 58; c++) expect_at(c, "bounce", v_idle(cc));
    repeat (3) begin
      start_btn = 1'b1;
      step(2);
      start_btn = 1'b0;
      step(2);
    end
    step(6);

    // door opened during RUN
    press_to_run(r);
    expect_at(r + 3, "door_run", v_run(cc));
    step(3);
    door_closed = 1'b0;
    expect_at(r + 5, "door_sync", v_run(cc));
    expect_at(r + 6, "door_fault", v_flt(2'b10, cc));
    step(3);
    door_closed = 1'b1;
    step(4);
    p = cyc;
    start_btn = 1'b1;
    expect_at(p + 6, "fault_hold", v_flt(2'b10, cc));
    expect_at(p + 7, "fault_clear", v_idle(cc));
    expect_at(p + 8, "no_lock", v_idle(cc));
    expect_at(p + 12, "no_relock", v_idle(cc));
    step(12);
    start_btn = 1'b0;
    step(8);

    // press ignored with the door open
    door_closed = 1'b0;
    step(3);
    press_expect("door_open_ign", v_idle(cc));
    door_closed = 1'b1;
    step(3);

    // watchdog timeout after 32 RUN cycles
    press_to_run(r);
    expect_at(r + 31, "wd_last", v_run(cc));
    expect_at(r + 32, "timeout", v_flt(2'b11, cc));
    step(32);
    press_expect("to_clear", v_idle(cc));

    // no water at start
    water_ok = 1'b0;
    press_expect("no_water", v_flt(2'b01, cc));
    press_expect("nw_hold", v_flt(2'b01, cc));
    water_ok = 1'b1;
    press_expect("nw_clear", v_idle(cc));

    // water lost during RUN
    press_to_run(r);
    water_ok = 1'b0;
    expect_at(r + 1, "run_no_water", v_flt(2'b01, cc));
    step(1);
    water_ok = 1'b1;
    step(6);
    press_expect("rnw_clear", v_idle(cc));

    // done_rise and door drop in the same RUN cycle
    press_to_run(r);
    door_closed = 1'b0;
    expect_at(r + 2, "sim_run", v_run(cc));
    step(2);
    done = 1'b1;
    expect_at(r + 3, "sim_unlock", v_idle(cc));
    cc++;
    expect_at(r + 4, "sim_idle", v_idle(cc));
    step(2);
    done        = 1'b0;
    door_closed = 1'b1;
    step(8);

    // saturation of cycle_count
    repeat (256) begin
      press_to_run(r);
      done = 1'b1;
      expect_at(r + 1, "sat_unlock", v_idle(cc));
      cc = (cc == 255) ? 255 : cc + 1;
      expect_at(r + 2, "sat_idle", v_idle(cc));
      step(2);
      done = 1'b0;
      step(6);
    end

    // reset while in RUN
    press_to_run(r);
    rst = 1'b1;
    expect_at(r + 1, "rst_run", v_idle(0));
    step(1);
    rst = 1'b0;
    expect_at(r + 3, "post_rst", v_idle(0));
    step(3);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
